// File: rtl/reg_file.sv
// Multi-ported register file: one synchronous write port and two combinational read ports.
// Reset clears every register asynchronously, and writes are ignored while reset is held.

module reg_file_cell #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] q_o
);
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (we_i) data_d = wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign q_o = data_q;
endmodule

module reg_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [ADDR_W-1:0] ad,
    input  logic [DATA_W-1:0] rd,
    input  logic [ADDR_W-1:0] aa,
    input  logic [ADDR_W-1:0] ab,
    output logic [DATA_W-1:0] ra,
    output logic [DATA_W-1:0] rb
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0]             we;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    // One-hot write decode; R0 is an ordinary register.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign we[i] = wr && (ad == ADDR_W'(i));

        reg_file_cell #(.DATA_W(DATA_W)) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (we[i]),
            .wdata_i (rd),
            .q_o     (regs[i])
        );
    end

    // Reads come straight from the registers with no bypass of rd, so a same-address
    // write becomes visible only after the edge.
    assign ra = regs[aa];
    assign rb = regs[ab];
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// checked against an array model of the register contents.

module tb_reg_file;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int NREG   = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr;
    logic [ADDR_W-1:0] ad, aa, ab;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] ra, rb;

    logic [DATA_W-1:0] mdl [NREG];
    int checks = 0;
    int failures = 0;

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .ad(ad), .rd(rd),
        .aa(aa), .ab(ab), .ra(ra), .rb(rb)
    );

    always #5 clk = ~clk;

    // Drive a write, advance one edge, and update the model if the write should have landed.
    task automatic write_cycle(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr = 1'b1; ad = a; rd = d;
        @(posedge clk); #1;
        if (rst_n === 1'b1) mdl[a] = d;
        wr = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; wr = 1'b0; ad = '0; rd = '0; aa = '0; ab = '0;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
        for (int a = 0; a < NREG; a++) begin
            aa = ADDR_W'(a); ab = ADDR_W'(NREG - 1 - a); #1;
            checks++;
            if (ra !== '0 || rb !== '0) begin
                failures++;
                $display("FAIL reset_read a=%0d: ra=%0d rb=%0d expected 0 0", a, ra, rb);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill;
        for (int i = 0; i < NREG; i++) write_cycle(ADDR_W'(i), DATA_W'(12 + i));
        aa = 2'd1; ab = 2'd3; #1;
        checks++;
        if (ra !== 8'd13 || rb !== 8'd15) begin
            failures++;
            $display("FAIL fill_read13: ra=%0d rb=%0d expected 13 15", ra, rb);
        end
        aa = 2'd2; ab = 2'd0; #1;
        checks++;
        if (ra !== 8'd14 || rb !== 8'd12) begin
            failures++;
            $display("FAIL fill_read20: ra=%0d rb=%0d expected 14 12", ra, rb);
        end
    endtask

    task automatic test_wr_disabled;
        wr = 1'b0; ad = 2'd1; rd = 8'd99;
        @(posedge clk); #1;
        aa = 2'd1; #1;
        checks++;
        if (ra !== 8'd13) begin
            failures++;
            $display("FAIL wr_disabled: ra=%0d expected 13", ra);
        end
    endtask

    task automatic test_read_during_write;
        aa = 2'd2; ab = 2'd3; wr = 1'b1; ad = 2'd2; rd = 8'd77; #1;
        checks++;
        if (ra !== 8'd14) begin
            failures++;
            $display("FAIL rdw_before: ra=%0d expected 14", ra);
        end
        @(posedge clk); #1;
        mdl[2] = 8'd77; wr = 1'b0;
        checks++;
        if (ra !== 8'd77 || rb !== 8'd15) begin
            failures++;
            $display("FAIL rdw_after: ra=%0d rb=%0d expected 77 15", ra, rb);
        end
    endtask

    task automatic test_dual_read;
        aa = 2'd0; ab = 2'd0; #1;
        checks++;
        if (ra !== 8'd12 || rb !== 8'd12) begin
            failures++;
            $display("FAIL dual_same: ra=%0d rb=%0d expected 12 12", ra, rb);
        end
    endtask

    task automatic test_mid_reset;
        // Reset lands mid-cycle and holds across an edge carrying a write.
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
        aa = 2'd3; ab = 2'd2; #1;
        checks++;
        if (ra !== '0 || rb !== '0) begin
            failures++;
            $display("FAIL midreset_async: ra=%0d rb=%0d expected 0 0", ra, rb);
        end
        write_cycle(2'd1, 8'd55);
        aa = 2'd1; #1;
        checks++;
        if (ra !== '0) begin
            failures++;
            $display("FAIL reset_write_ignored: ra=%0d expected 0", ra);
        end
        rst_n = 1'b1;
        write_cycle(2'd3, 8'd5);
        for (int a = 0; a < NREG; a++) begin
            aa = ADDR_W'(a); ab = ADDR_W'(a); #1;
            checks++;
            if (ra !== (a == 3 ? 8'd5 : 8'd0) || rb !== ra) begin
                failures++;
                $display("FAIL post_reset_R%0d: ra=%0d rb=%0d expected %0d", a, ra, rb,
                         (a == 3 ? 5 : 0));
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom_range(0, 1));
            ad = ADDR_W'($urandom); rd = DATA_W'($urandom);
            aa = ADDR_W'($urandom); ab = ADDR_W'($urandom);
            #1;
            checks++;
            if (ra !== mdl[aa] || rb !== mdl[ab]) begin
                failures++;
                $display("FAIL random_pre n=%0d aa=%0d ab=%0d: ra=%0d rb=%0d expected %0d %0d",
                         n, aa, ab, ra, rb, mdl[aa], mdl[ab]);
            end
            @(posedge clk); #1;
            if (wr) mdl[ad] = rd;
            checks++;
            if (ra !== mdl[aa] || rb !== mdl[ab]) begin
                failures++;
                $display("FAIL random_post n=%0d aa=%0d ab=%0d: ra=%0d rb=%0d expected %0d %0d",
                         n, aa, ab, ra, rb, mdl[aa], mdl[ab]);
            end
        end
        wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wr_disabled();
        test_read_during_write();
        test_dual_read();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
